sync_fifo_pop: RTL and testbench

Pop-side adapter that sits directly downstream of `sync_fifo`. It drains the FIFO's read port (`fifo_re`/`fifo_rd`/`fifo_empt`) into a small registered skid buffer and presents the data as a valid/ready stream. It hides the FIFO's configurable read latency and sustains one beat per cycle without any combinational path from `m_rdy` to `fifo_re`.

---
 rtl/sync_fifo_pop.sv | 109 ++++++++++
 tb/tb_sync_fifo_pop.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_pop.sv
// rtl/sync_fifo_pop.sv - pop-side skid buffer turning a sync_fifo read port into a valid/ready stream
// Optional SYNC_FIFO_POP_STAT_EN adds stat_beats/stat_stall counters.
module sync_fifo_pop #(
    parameter int FIFO_W = 32,
    parameter int RD_DLY = 0,
    parameter int BUF_D  = RD_DLY + 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fsh,
    output logic                         fifo_re,
    input  logic [FIFO_W-1:0]            fifo_rd,
    input  logic                         fifo_empt,
    output logic                         fifo_fsh,
    output logic                         m_vld,
    output logic [FIFO_W-1:0]            m_dat,
    input  logic                         m_rdy,
`ifdef SYNC_FIFO_POP_STAT_EN
    output logic [31:0]                  stat_beats,
    output logic [31:0]                  stat_stall,
`endif
    output logic [$clog2(BUF_D+1)-1:0]   buf_len
);

    localparam int LW = $clog2(BUF_D + 1);
    localparam int PW = (BUF_D > 1) ? $clog2(BUF_D) : 1;

    logic [FIFO_W-1:0] mem [BUF_D];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     rd_ptr_nxt;
    logic              infl;
    logic              cap;
    logic              drn;
    logic [LW:0]       credit;
    logic [LW-1:0]     len_nxt;
    logic [FIFO_W-1:0] head_nxt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_D - 1)) ? '0 : p + PW'(1);
    endfunction

    assign fifo_fsh = fsh;
    // Credit counts pops still in flight so the buffer can never overflow.
    assign credit   = {1'b0, buf_len} + {{LW{1'b0}}, infl};
    assign fifo_re  = ~rst & ~fsh & ~fifo_empt & (credit < (LW+1)'(BUF_D));
    assign cap      = (RD_DLY == 0) ? fifo_re : infl;
    assign drn      = m_vld & m_rdy;

    always_comb begin
        rd_ptr_nxt = drn ? ptr_inc(rd_ptr) : rd_ptr;
        len_nxt    = buf_len;
        if (cap && !drn) begin
            len_nxt = buf_len + LW'(1);
        end else if (!cap && drn) begin
            len_nxt = buf_len - LW'(1);
        end
        // m_dat mirrors the head; a fresh capture becomes head only if nothing older survives.
        head_nxt = m_dat;
        if ((buf_len == '0) || ((buf_len == LW'(1)) && drn)) begin
            if (cap) begin
                head_nxt = fifo_rd;
            end
        end else begin
            head_nxt = mem[rd_ptr_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (cap && !rst && !fsh) begin
            mem[wr_ptr] <= fifo_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || fsh) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            buf_len <= '0;
            infl    <= 1'b0;
            m_vld   <= 1'b0;
            if (rst) begin
                m_dat <= '0;
            end
        end else begin
            infl    <= (RD_DLY != 0) && fifo_re;
            if (cap) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            rd_ptr  <= rd_ptr_nxt;
            buf_len <= len_nxt;
            m_vld   <= (len_nxt != '0);
            m_dat   <= head_nxt;
        end
    end

`ifdef SYNC_FIFO_POP_STAT_EN
    always_ff @(posedge clk) begin
        if (rst || fsh) begin
            stat_beats <= '0;
            stat_stall <= '0;
        end else begin
            stat_beats <= stat_beats + 32'(drn);
            stat_stall <= stat_stall + 32'(m_vld & ~m_rdy);
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_pop.sv
// tb/tb_sync_fifo_pop.sv - random/directed bench for sync_fifo_pop with RD_DLY 0 and 1 side by side
module tb_sync_fifo_pop;

    logic        clk = 1'b0;
    logic        rst;
    logic        fsh;
    logic        rdy;
    logic        re   [2];
    logic        empt [2];
    logic        ffsh [2];
    logic        vld  [2];
    logic [31:0] rd   [2];
    logic [31:0] dat  [2];
    logic [1:0]  len  [2];
`ifdef SYNC_FIFO_POP_STAT_EN
    logic [31:0] sbeat [2];
    logic [31:0] sstal [2];
`endif

    always #5 clk = ~clk;

    sync_fifo_pop #(.FIFO_W(32), .RD_DLY(0)) u0 (
        .clk(clk), .rst(rst), .fsh(fsh), .fifo_re(re[0]), .fifo_rd(rd[0]),
        .fifo_empt(empt[0]), .fifo_fsh(ffsh[0]), .m_vld(vld[0]), .m_dat(dat[0]),
        .m_rdy(rdy),
`ifdef SYNC_FIFO_POP_STAT_EN
        .stat_beats(sbeat[0]), .stat_stall(sstal[0]),
`endif
        .buf_len(len[0]));

    sync_fifo_pop #(.FIFO_W(32), .RD_DLY(1)) u1 (
        .clk(clk), .rst(rst), .fsh(fsh), .fifo_re(re[1]), .fifo_rd(rd[1]),
        .fifo_empt(empt[1]), .fifo_fsh(ffsh[1]), .m_vld(vld[1]), .m_dat(dat[1]),
        .m_rdy(rdy),
`ifdef SYNC_FIFO_POP_STAT_EN
        .stat_beats(sbeat[1]), .stat_stall(sstal[1]),
`endif
        .buf_len(len[1]));

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] fq [2][$];
    logic [31:0] sb [2][$];
    logic        re_s   [2];
    logic        infl_m [2];
    logic        hold_v [2];
    logic [31:0] hold_d [2];
    int          first_re [2];
    int          first_vld [2];
    int          nbeats [2];
    int          last_beat [2];
    int          st_b [2];
    int          st_s [2];
    logic        fsh_s;
    logic        rst_s;
    logic        push_en;
    logic [31:0] push_dat;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int bd(input int i);
        return i + 2;
    endfunction

    task automatic refresh();
        for (int i = 0; i < 2; i++) begin
            empt[i] = (fq[i].size() == 0);
        end
        rd[0] = empt[0] ? 32'h0 : fq[0][0];
    endtask

    task automatic clear_marks();
        for (int i = 0; i < 2; i++) begin
            first_re[i]  = -1;
            first_vld[i] = -1;
            nbeats[i]    = 0;
            last_beat[i] = -1;
        end
    endtask

    task automatic load(input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 2; i++) begin
                fq[i].push_back(base + 32'(k));
                sb[i].push_back(base + 32'(k));
            end
        end
        refresh();
    endtask

    // One clock cycle: check outputs mid-cycle, then advance the upstream FIFO model after the edge.
    task automatic step();
        logic [31:0] w;
        logic [31:0] exp;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("len_max", 32'(int'(len[i]) <= bd(i)), 32'd1);
            chk("vld_len", 32'(vld[i]), 32'(len[i] != 2'd0));
            chk("fsh_pass", 32'(ffsh[i]), 32'(fsh));
            if (rst || fsh) chk("re_block", 32'(re[i]), 32'd0);
            if (re[i]) begin
                chk("re_empty", 32'(empt[i]), 32'd0);
                chk("re_credit", 32'((int'(len[i]) + int'(infl_m[i])) < bd(i)), 32'd1);
                if (first_re[i] < 0) first_re[i] = cyc;
            end
            if (hold_v[i]) begin
                chk("hold_vld", 32'(vld[i]), 32'd1);
                chk("hold_dat", dat[i], hold_d[i]);
            end
            if (vld[i] && first_vld[i] < 0) first_vld[i] = cyc;
            if (vld[i] && rdy && !fsh && !rst) begin
                nbeats[i]++;
                last_beat[i] = cyc;
                exp = (sb[i].size() != 0) ? sb[i].pop_front() : ~dat[i];
                chk("beat", dat[i], exp);
            end
            if (!fsh && !rst) begin
                if (vld[i] && rdy) st_b[i]++;
                if (vld[i] && !rdy) st_s[i]++;
            end
            hold_v[i] = vld[i] & ~rdy & ~fsh & ~rst;
            hold_d[i] = dat[i];
            re_s[i]   = re[i];
        end
        fsh_s = fsh;
        rst_s = rst;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            infl_m[i] = (i == 1) && re_s[i] && !fsh_s && !rst_s;
            if (fsh_s || rst_s) begin
                st_b[i] = 0;
                st_s[i] = 0;
            end
            if (fsh_s) begin
                fq[i].delete();
                sb[i].delete();
            end else if (re_s[i]) begin
                w = fq[i].pop_front();
                if (i == 1) rd[1] = w;
            end
            if (push_en && !fsh_s) begin
                fq[i].push_back(push_dat);
                sb[i].push_back(push_dat);
            end
        end
        refresh();
    endtask

    initial begin
        int k;
        int t;
`ifdef SYNC_FIFO_POP_STAT_EN
        logic rdy_pat [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
`endif
        rst = 1'b1; fsh = 1'b0; rdy = 1'b0; push_en = 1'b0; push_dat = '0;
        rd[1] = '0;
        for (int i = 0; i < 2; i++) begin
            re_s[i] = 0; infl_m[i] = 0; hold_v[i] = 0; hold_d[i] = '0; st_b[i] = 0; st_s[i] = 0;
        end
        clear_marks();
        refresh();
        @(posedge clk);
        #1;
        step();
        for (int i = 0; i < 2; i++) begin
            chk("rst_vld", 32'(vld[i]), 32'd0);
            chk("rst_dat", dat[i], 32'd0);
            chk("rst_len", 32'(len[i]), 32'd0);
            chk("rst_re", 32'(re[i]), 32'd0);
        end

        // Streaming: words preloaded while in reset, full-rate drain.
        load(32'h10, 8);
        clear_marks();
        rst = 1'b0; rdy = 1'b1;
        repeat (14) step();
        for (int i = 0; i < 2; i++) begin
            chk("stream_lat", 32'(first_vld[i] - first_re[i]), 32'(1 + i));
            chk("stream_cnt", 32'(nbeats[i]), 32'd8);
            chk("stream_b2b", 32'(last_beat[i] - first_vld[i]), 32'd7);
            chk("stream_left", 32'(sb[i].size()), 32'd0);
        end

        // Backpressure: six words, ready low for ten cycles.
        fsh = 1'b1; rdy = 1'b0;
        step();
        fsh = 1'b0;
        load(32'h20, 6);
        repeat (10) step();
        for (int i = 0; i < 2; i++) begin
            chk("bp_len", 32'(len[i]), 32'(bd(i)));
            chk("bp_re", 32'(re[i]), 32'd0);
            chk("bp_dat", dat[i], 32'h20);
            chk("bp_fifo", 32'(fq[i].size()), 32'(6 - bd(i)));
        end
        rdy = 1'b1;
        repeat (12) step();
        for (int i = 0; i < 2; i++) chk("bp_drain", 32'(sb[i].size()), 32'd0);

        // Flush one cycle after a pop so RD_DLY=1 has a word in flight.
        load(32'h30, 4);
        step();
        fsh = 1'b1;
        #1;
        chk("fl_fsh", 32'(ffsh[1]), 32'd1);
        chk("fl_re", 32'(re[1]), 32'd0);
        chk("fl_infl", 32'(infl_m[1]), 32'd1);
        step();
        fsh = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("fl_vld", 32'(vld[i]), 32'd0);
            chk("fl_len", 32'(len[i]), 32'd0);
        end
        clear_marks();
        repeat (5) step();
        for (int i = 0; i < 2; i++) chk("fl_leak", 32'(nbeats[i]), 32'd0);

        // Random ready and random pushes of 1000 incrementing words.
        clear_marks();
        k = 0; t = 0;
        while ((k < 1000 || sb[0].size() != 0 || sb[1].size() != 0) && t < 20000) begin
            rdy      = 1'($urandom_range(0, 1));
            push_en  = (k < 1000) && ($urandom_range(0, 9) < 7);
            push_dat = 32'h1000 + 32'(k);
            if (push_en) k++;
            step();
            t++;
        end
        push_en = 1'b0;
        chk("rand_pushed", 32'(k), 32'd1000);
        for (int i = 0; i < 2; i++) begin
            chk("rand_left", 32'(sb[i].size()), 32'd0);
            chk("rand_beats", 32'(nbeats[i]), 32'd1000);
        end

`ifdef SYNC_FIFO_POP_STAT_EN
        fsh = 1'b1; rdy = 1'b0;
        step();
        fsh = 1'b0;
        load(32'h40, 5);
        for (int j = 0; j < 8; j++) begin
            rdy = rdy_pat[j];
            step();
        end
        rdy = 1'b1;
        repeat (6) step();
        rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("stat_beats", sbeat[i], 32'(st_b[i]));
            chk("stat_stall", sstal[i], 32'(st_s[i]));
            chk("stat_five", sbeat[i], 32'd5);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("stat_rst_b", sbeat[i], 32'd0);
            chk("stat_rst_s", sstal[i], 32'd0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
